cpu_msg_arbiter: RTL and testbench
==================================

Name: cpu_msg_arbiter

Overview:
Merges three CPU-message sources onto ringleader's single, readyless CPU-message port (queue, valid, msg). The sources are queue configuration, monitor re-arm hints and packet-done/free-memory feedback.
Done grants also issue the matching free-memory request in the same cycle, so buffer release and credit return stay atomic.
Priority is fixed (cfg > hint > done), with starvation promotion for done and a programmable minimum gap between issued messages. The block sits between host/feedback logic and ringleader's s_axis_cpu_msg_* / free_mem_* ports.

Parameters:
QUEUE_INDEX_WIDTH, 6, queue index width
CPU_MSG_WIDTH, 32, CPU message width
APP_ID_WIDTH, 4, application id width
RAM_ADDR_WIDTH, 20, packet buffer address width
LEN_WIDTH, 16, buffer length width
MIN_GAP, 1, minimum cycles between consecutive output messages (>=1)
STARVE_LIMIT, 15, cycles a pending done request may lose arbitration before promotion (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_cfg_valid  in  1  config message valid
s_cfg_ready  out  1  config accepted this cycle
s_cfg_queue  in  QUEUE_INDEX_WIDTH  config target queue
s_cfg_msg  in  CPU_MSG_WIDTH  config message, passed verbatim
s_hint_valid  in  1  hint re-arm valid
s_hint_ready  out  1  hint accepted
s_hint_queue  in  QUEUE_INDEX_WIDTH  hint queue
s_hint_msg  in  CPU_MSG_WIDTH  prebuilt arm message, passed verbatim
s_done_valid  in  1  done/feedback valid
s_done_ready  out  1  done accepted
s_done_queue  in  QUEUE_INDEX_WIDTH  queue the packet was consumed from
s_done_app_id  in  APP_ID_WIDTH  application id
s_done_addr  in  RAM_ADDR_WIDTH  buffer address to free
s_done_len  in  LEN_WIDTH  buffer size to free
free_mem_ready  in  1  allocator can accept a free
free_mem_req  out  1  free request, one-cycle pulse
free_mem_addr  out  RAM_ADDR_WIDTH  freed address
free_mem_size  out  LEN_WIDTH  freed size
m_cpu_msg_valid  out  1  message valid, one-cycle pulse, no backpressure
m_cpu_msg_queue  out  QUEUE_INDEX_WIDTH  message queue
m_cpu_msg  out  CPU_MSG_WIDTH  message
grant_count_done  out  32  saturating count of done grants (debug)

Behaviour:
- Reset (async, rst_n=0): all outputs 0; gap_cnt=0; wait_cnt=0; grant_count_done=0. Reset mid-transfer drops the registered message; it is not replayed.
- Eligibility, combinational: cfg_el=s_cfg_valid; hint_el=s_hint_valid; done_el=s_done_valid && free_mem_ready. All are gated by gap_cnt==0.
- Grant, one-hot:
  - Normal priority is cfg > hint > done.
  - If wait_cnt==STARVE_LIMIT and done_el, done wins over everything.
- s_X_ready = grant_X (combinational). A transfer occurs on valid && ready. At most one transfer per cycle.
- Latency: outputs are registered and appear exactly 1 cycle after the transfer. m_cpu_msg_valid and free_mem_req deassert the next cycle unless there is another grant.
- Done message format:
  - m_cpu_msg = {16'd1 in [31:16], 0, app_id in [4 +: APP_ID_WIDTH], CPU_MSG_OPC_DONE (4'h5) in [3:0]}.
  - free_mem_req=1 with addr/len in the same cycle as m_cpu_msg_valid.
- cfg/hint messages pass s_*_msg and s_*_queue unchanged; free_mem_req=0.
- gap_cnt: on any grant, load MIN_GAP-1; else decrement if nonzero. MIN_GAP=1 allows back-to-back grants every cycle.
- wait_cnt: increments (saturating at STARVE_LIMIT) each cycle s_done_valid=1 and done is not granted, including gap-blocked cycles and cycles with free_mem_ready=0. Cleared on a done grant, or when s_done_valid=0.
- A promoted done still requires free_mem_ready. While that is low, cfg/hint are granted normally and wait_cnt holds at STARVE_LIMIT.
- grant_count_done increments on each done grant and saturates at 2^32-1.
- Simultaneous valid on all three with gap_cnt==0: cfg granted, others stall; inputs must hold stable while valid && !ready.

Decomposition:
- Package ringleader_msg_pkg holds:
  - CPU_MSG_OPC_DONE=4'h5, plus the existing CPU_MSG_* arm opcodes;
  - the message field offsets (opcode [3:0], app_id at bit 4, count at bit 16);
  - a function building a done message from app_id.
- One sub-module, msg_prio_grant: 3-input fixed-priority one-hot grant with a promote input.
- Counters and output registers stay in the top.

Test Plan:
- MIN_GAP=1, cfg valid queue=2 msg=0x1413 for 1 cycle -> s_cfg_ready=1 same cycle; next cycle m_cpu_msg_valid=1, queue=2, msg=0x1413, free_mem_req=0.
- done app_id=1, queue=3, addr=0x00400, len=256, free_mem_ready=1 -> next cycle m_cpu_msg=0x00010015, queue=3; free_mem_req=1 with addr=0x00400, size=256; grant_count_done=1.
- done valid with free_mem_ready=0 for 10 cycles -> s_done_ready=0 and no outputs; ready rises -> grant and outputs 1 cycle later.
- cfg+hint+done valid continuously, STARVE_LIMIT=15 -> cfg granted for 15 cycles, done granted on cycle 16 (wait_cnt=15), then cfg resumes.
- MIN_GAP=2, hint valid continuously -> m_cpu_msg_valid pulses every 2nd cycle, never on consecutive cycles.
- rst_n dropped the cycle after a done grant -> free_mem_req and m_cpu_msg_valid are 0 immediately (asynchronous); after release no stale message is emitted.

Source files
------------

// File: rtl/ringleader_msg_pkg.sv
// Shared CPU-message definitions: opcodes, field layout and the done-message builder.
package ringleader_msg_pkg;

  // Opcodes carried in the low nibble of every CPU message
  localparam logic [3:0] CPU_MSG_OPC_ARM      = 4'h1;
  localparam logic [3:0] CPU_MSG_OPC_ARM_ONCE = 4'h2;
  localparam logic [3:0] CPU_MSG_OPC_DISARM   = 4'h3;
  localparam logic [3:0] CPU_MSG_OPC_DONE     = 4'h5;

  // Field layout of a CPU message
  localparam int CPU_MSG_OPC_LSB = 0;
  localparam int CPU_MSG_OPC_W   = 4;
  localparam int CPU_MSG_APP_LSB = 4;
  localparam int CPU_MSG_APP_W   = 12;
  localparam int CPU_MSG_CNT_LSB = 16;
  localparam int CPU_MSG_CNT_W   = 16;

  // One-hot grant across the three message sources
  typedef struct packed {
    logic cfg;
    logic hint;
    logic done;
  } grant_t;

  // A done message returns exactly one packet credit for the given application
  function automatic logic [31:0] build_done_msg(input logic [CPU_MSG_APP_W-1:0] app_id);
    logic [31:0] msg;
    msg = '0;
    msg[CPU_MSG_OPC_LSB +: CPU_MSG_OPC_W] = CPU_MSG_OPC_DONE;
    msg[CPU_MSG_APP_LSB +: CPU_MSG_APP_W] = app_id;
    msg[CPU_MSG_CNT_LSB +: CPU_MSG_CNT_W] = 16'd1;
    return msg;
  endfunction

endpackage

// File: rtl/msg_prio_grant.sv
// Fixed-priority (cfg > hint > done) one-hot grant with a promotion override for done.
module msg_prio_grant
  import ringleader_msg_pkg::*;
(
  input  logic   i_gate,
  input  logic   i_req_cfg,
  input  logic   i_req_hint,
  input  logic   i_req_done,
  input  logic   i_promote,
  output grant_t o_grant
);

  // Pick at most one winner; a promoted done jumps ahead of cfg and hint
  always_comb begin
    o_grant = '0;
    if (i_gate) begin
      if (i_promote && i_req_done) begin
        o_grant.done = 1'b1;
      end else if (i_req_cfg) begin
        o_grant.cfg = 1'b1;
      end else if (i_req_hint) begin
        o_grant.hint = 1'b1;
      end else if (i_req_done) begin
        o_grant.done = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_msg_arbiter.sv
// Merges cfg, hint and done/feedback sources onto a single readyless CPU-message port.
// Done grants also emit the matching free-memory request in the same output cycle.
module cpu_msg_arbiter
  import ringleader_msg_pkg::*;
#(
  parameter int QUEUE_INDEX_WIDTH = 6,
  parameter int CPU_MSG_WIDTH     = 32,
  parameter int APP_ID_WIDTH      = 4,
  parameter int RAM_ADDR_WIDTH    = 20,
  parameter int LEN_WIDTH         = 16,
  parameter int MIN_GAP           = 1,
  parameter int STARVE_LIMIT      = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_cfg_valid,
  output logic                         s_cfg_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_cfg_queue,
  input  logic [CPU_MSG_WIDTH-1:0]     s_cfg_msg,
  input  logic                         s_hint_valid,
  output logic                         s_hint_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_hint_queue,
  input  logic [CPU_MSG_WIDTH-1:0]     s_hint_msg,
  input  logic                         s_done_valid,
  output logic                         s_done_ready,
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_done_queue,
  input  logic [APP_ID_WIDTH-1:0]      s_done_app_id,
  input  logic [RAM_ADDR_WIDTH-1:0]    s_done_addr,
  input  logic [LEN_WIDTH-1:0]         s_done_len,
  input  logic                         free_mem_ready,
  output logic                         free_mem_req,
  output logic [RAM_ADDR_WIDTH-1:0]    free_mem_addr,
  output logic [LEN_WIDTH-1:0]         free_mem_size,
  output logic                         m_cpu_msg_valid,
  output logic [QUEUE_INDEX_WIDTH-1:0] m_cpu_msg_queue,
  output logic [CPU_MSG_WIDTH-1:0]     m_cpu_msg,
  output logic [31:0]                  grant_count_done
);

  localparam int                GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [GAP_W-1:0]                r_gap_cnt;
  logic [WAIT_W-1:0]               r_wait_cnt;
  logic                            r_msg_valid;
  logic [QUEUE_INDEX_WIDTH-1:0]    r_msg_queue;
  logic [CPU_MSG_WIDTH-1:0]        r_msg;
  logic                            r_free_req;
  logic [RAM_ADDR_WIDTH-1:0]       r_free_addr;
  logic [LEN_WIDTH-1:0]            r_free_size;
  logic [31:0]                     r_grant_cnt;

  logic                            w_gap_ok;
  logic                            w_done_el;
  logic                            w_promote;
  logic                            w_any_grant;
  logic [CPU_MSG_APP_W-1:0]        w_app_ext;
  grant_t                          w_grant;

  assign w_gap_ok    = (r_gap_cnt == '0);
  // Done can only win when the allocator can take the paired free in the same cycle
  assign w_done_el   = s_done_valid && free_mem_ready;
  assign w_promote   = (r_wait_cnt == WAIT_MAX);
  assign w_app_ext   = CPU_MSG_APP_W'(s_done_app_id);
  assign w_any_grant = w_grant.cfg || w_grant.hint || w_grant.done;

  msg_prio_grant u_grant (
    .i_gate     (w_gap_ok),
    .i_req_cfg  (s_cfg_valid),
    .i_req_hint (s_hint_valid),
    .i_req_done (w_done_el),
    .i_promote  (w_promote),
    .o_grant    (w_grant)
  );

  assign s_cfg_ready      = w_grant.cfg;
  assign s_hint_ready     = w_grant.hint;
  assign s_done_ready     = w_grant.done;

  assign m_cpu_msg_valid  = r_msg_valid;
  assign m_cpu_msg_queue  = r_msg_queue;
  assign m_cpu_msg        = r_msg;
  assign free_mem_req     = r_free_req;
  assign free_mem_addr    = r_free_addr;
  assign free_mem_size    = r_free_size;
  assign grant_count_done = r_grant_cnt;

  // Enforce the minimum spacing between issued messages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if (w_any_grant) begin
      r_gap_cnt <= GAP_LOAD;
    end else if (r_gap_cnt != '0) begin
      r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  // Count consecutive cycles a pending done has been passed over (any reason)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!s_done_valid || w_grant.done) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Register the granted message; payload holds between grants, valid/req pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_valid <= 1'b0;
      r_msg_queue <= '0;
      r_msg       <= '0;
      r_free_req  <= 1'b0;
      r_free_addr <= '0;
      r_free_size <= '0;
    end else begin
      r_msg_valid <= w_any_grant;
      r_free_req  <= w_grant.done;
      if (w_grant.cfg) begin
        r_msg_queue <= s_cfg_queue;
        r_msg       <= s_cfg_msg;
      end else if (w_grant.hint) begin
        r_msg_queue <= s_hint_queue;
        r_msg       <= s_hint_msg;
      end else if (w_grant.done) begin
        r_msg_queue <= s_done_queue;
        r_msg       <= CPU_MSG_WIDTH'(build_done_msg(w_app_ext));
        r_free_addr <= s_done_addr;
        r_free_size <= s_done_len;
      end
    end
  end

  // Saturating debug count of done grants
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
    end else if (w_grant.done && (r_grant_cnt != 32'hFFFF_FFFF)) begin
      r_grant_cnt <= r_grant_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_msg_arbiter.sv
// Self-checking bench: two arbiters (MIN_GAP=1 and MIN_GAP=2) share one directed stimulus;
// each is checked every cycle against a cycle-level reference model, plus literal spot checks.
module tb_cpu_msg_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid, hint_valid, done_valid, fm_ready;
  logic [5:0]  cfg_queue, hint_queue, done_queue;
  logic [31:0] cfg_msg, hint_msg;
  logic [3:0]  done_app;
  logic [19:0] done_addr;
  logic [15:0] done_len;

  logic        cfg_rdy [2];
  logic        hint_rdy[2];
  logic        done_rdy[2];
  logic        fm_req  [2];
  logic [19:0] fm_addr [2];
  logic [15:0] fm_size [2];
  logic        mv      [2];
  logic [5:0]  mq      [2];
  logic [31:0] mmsg    [2];
  logic [31:0] gcnt    [2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int MG = gi + 1;
      localparam int SL = 15;

      cpu_msg_arbiter #(
        .QUEUE_INDEX_WIDTH (6),
        .CPU_MSG_WIDTH     (32),
        .APP_ID_WIDTH      (4),
        .RAM_ADDR_WIDTH    (20),
        .LEN_WIDTH         (16),
        .MIN_GAP           (MG),
        .STARVE_LIMIT      (SL)
      ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_cfg_valid      (cfg_valid),
        .s_cfg_ready      (cfg_rdy[gi]),
        .s_cfg_queue      (cfg_queue),
        .s_cfg_msg        (cfg_msg),
        .s_hint_valid     (hint_valid),
        .s_hint_ready     (hint_rdy[gi]),
        .s_hint_queue     (hint_queue),
        .s_hint_msg       (hint_msg),
        .s_done_valid     (done_valid),
        .s_done_ready     (done_rdy[gi]),
        .s_done_queue     (done_queue),
        .s_done_app_id    (done_app),
        .s_done_addr      (done_addr),
        .s_done_len       (done_len),
        .free_mem_ready   (fm_ready),
        .free_mem_req     (fm_req[gi]),
        .free_mem_addr    (fm_addr[gi]),
        .free_mem_size    (fm_size[gi]),
        .m_cpu_msg_valid  (mv[gi]),
        .m_cpu_msg_queue  (mq[gi]),
        .m_cpu_msg        (mmsg[gi]),
        .grant_count_done (gcnt[gi])
      );

      // Reference model: cycles since last grant, cycles done has been passed over
      int          age;
      int          lost;
      logic        gap_ok, g_cfg, g_hint, g_done;
      logic        e_valid, e_free;
      logic [5:0]  e_queue;
      logic [31:0] e_msg;
      logic [19:0] e_addr;
      logic [15:0] e_size;
      logic [31:0] e_cnt;

      always_comb begin
        gap_ok = (age >= MG);
        g_done = gap_ok && done_valid && fm_ready &&
                 ((lost >= SL) || (!cfg_valid && !hint_valid));
        g_cfg  = gap_ok && cfg_valid && !g_done;
        g_hint = gap_ok && hint_valid && !cfg_valid && !g_done;
      end

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age     <= 1000;
          lost    <= 0;
          e_valid <= 1'b0;
          e_free  <= 1'b0;
          e_queue <= '0;
          e_msg   <= '0;
          e_addr  <= '0;
          e_size  <= '0;
          e_cnt   <= '0;
        end else begin
          age     <= (g_cfg || g_hint || g_done) ? 1 : ((age < 1000) ? age + 1 : age);
          lost    <= (!done_valid || g_done) ? 0 : ((lost < SL) ? lost + 1 : SL);
          e_valid <= g_cfg || g_hint || g_done;
          e_free  <= g_done;
          if (g_cfg) begin
            e_queue <= cfg_queue;
            e_msg   <= cfg_msg;
          end else if (g_hint) begin
            e_queue <= hint_queue;
            e_msg   <= hint_msg;
          end else if (g_done) begin
            e_queue <= done_queue;
            e_msg   <= (32'd1 << 16) | (32'(done_app) << 4) | 32'h5;
            e_addr  <= done_addr;
            e_size  <= done_len;
            e_cnt   <= e_cnt + 32'd1;
          end
        end
      end

      // Compare every cycle mid-period, where inputs and outputs are both settled
      always @(negedge clk) begin
        check($sformatf("g%0d_cfg_ready", gi), 64'(cfg_rdy[gi]), 64'(g_cfg));
        check($sformatf("g%0d_hint_ready", gi), 64'(hint_rdy[gi]), 64'(g_hint));
        check($sformatf("g%0d_done_ready", gi), 64'(done_rdy[gi]), 64'(g_done));
        check($sformatf("g%0d_msg_valid", gi), 64'(mv[gi]), 64'(e_valid));
        check($sformatf("g%0d_free_req", gi), 64'(fm_req[gi]), 64'(e_free));
        check($sformatf("g%0d_grant_count", gi), 64'(gcnt[gi]), 64'(e_cnt));
        if (e_valid) begin
          check($sformatf("g%0d_msg_queue", gi), 64'(mq[gi]), 64'(e_queue));
          check($sformatf("g%0d_msg", gi), 64'(mmsg[gi]), 64'(e_msg));
        end
        if (e_free) begin
          check($sformatf("g%0d_free_addr", gi), 64'(fm_addr[gi]), 64'(e_addr));
          check($sformatf("g%0d_free_size", gi), 64'(fm_size[gi]), 64'(e_size));
        end
      end
    end
  endgenerate

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg_valid  = 1'b0;
    hint_valid = 1'b0;
    done_valid = 1'b0;
  endtask

  // Stimulus with hand-computed spot checks (instance 0 is MIN_GAP=1, instance 1 is MIN_GAP=2)
  initial begin
    int pulses;
    logic prev_v;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0; cfg_queue  = '0; cfg_msg  = '0;
    hint_valid = 1'b0; hint_queue = '0; hint_msg = '0;
    done_valid = 1'b0; done_queue = '0; done_app = '0;
    done_addr  = '0;   done_len   = '0; fm_ready = 1'b0;

    repeat (3) cycle();
    @(negedge clk);
    check("reset_msg_valid", 64'(mv[0]), 64'd0);
    check("reset_free_req", 64'(fm_req[0]), 64'd0);
    check("reset_grant_count", 64'(gcnt[0]), 64'd0);
    $display("txn reset released");
    cycle();
    rst_n = 1'b1;
    cycle();

    // cfg pass-through
    cfg_valid = 1'b1; cfg_queue = 6'd2; cfg_msg = 32'h1413;
    @(negedge clk);
    check("cfg_ready_same_cycle", 64'(cfg_rdy[0]), 64'd1);
    cycle();
    clear_inputs();
    @(negedge clk);
    check("cfg_out_valid", 64'(mv[0]), 64'd1);
    check("cfg_out_queue", 64'(mq[0]), 64'd2);
    check("cfg_out_msg", 64'(mmsg[0]), 64'h1413);
    check("cfg_out_no_free", 64'(fm_req[0]), 64'd0);
    $display("txn cfg queue=2 msg=0x1413");
    cycle();

    // done with paired free
    done_valid = 1'b1; done_app = 4'd1; done_queue = 6'd3;
    done_addr = 20'h00400; done_len = 16'd256; fm_ready = 1'b1;
    cycle();
    clear_inputs();
    @(negedge clk);
    check("done_out_msg", 64'(mmsg[0]), 64'h0001_0015);
    check("done_out_queue", 64'(mq[0]), 64'd3);
    check("done_free_req", 64'(fm_req[0]), 64'd1);
    check("done_free_addr", 64'(fm_addr[0]), 64'h00400);
    check("done_free_size", 64'(fm_size[0]), 64'd256);
    check("done_grant_count", 64'(gcnt[0]), 64'd1);
    $display("txn done app=1 queue=3 addr=0x00400 len=256");
    cycle();

    // done blocked by allocator backpressure
    fm_ready = 1'b0; done_valid = 1'b1; done_app = 4'd7; done_addr = 20'h12340; done_len = 16'd64;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("blocked_done_ready", 64'(done_rdy[0]), 64'd0);
      check("blocked_no_free", 64'(fm_req[0]), 64'd0);
      cycle();
    end
    fm_ready = 1'b1;
    @(negedge clk);
    check("unblocked_done_ready", 64'(done_rdy[0]), 64'd1);
    cycle();
    clear_inputs();
    @(negedge clk);
    check("unblocked_free_req", 64'(fm_req[0]), 64'd1);
    check("unblocked_free_addr", 64'(fm_addr[0]), 64'h12340);
    $display("txn done app=7 after 10 blocked cycles");
    repeat (3) cycle();

    // starvation promotion: all three valid continuously
    cfg_valid = 1'b1; cfg_queue = 6'd9; cfg_msg = 32'hC0FFEE01;
    hint_valid = 1'b1; hint_queue = 6'd4; hint_msg = 32'h0000_4401;
    done_valid = 1'b1; done_app = 4'd2; done_queue = 6'd5; done_addr = 20'h0A000; done_len = 16'd128;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check($sformatf("starve_cfg_grant_%0d", k), 64'(cfg_rdy[0]), 64'(k != 16));
      check($sformatf("starve_done_grant_%0d", k), 64'(done_rdy[0]), 64'(k == 16));
      cycle();
    end
    clear_inputs();
    $display("txn starvation: done granted on cycle 16");
    repeat (4) cycle();

    // minimum gap: hint held valid
    hint_valid = 1'b1; hint_queue = 6'd1; hint_msg = 32'h0000_0011;
    pulses = 0;
    prev_v = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      @(negedge clk);
      check($sformatf("gap1_valid_%0d", k), 64'(mv[0]), 64'd1);
      check($sformatf("gap2_valid_%0d", k), 64'(mv[1]), 64'((k % 2) == 0));
      check($sformatf("gap2_no_back_to_back_%0d", k), 64'(prev_v && mv[1]), 64'd0);
      prev_v = mv[1];
      if (mv[1]) pulses++;
    end
    check("gap2_pulse_count", 64'(pulses), 64'd4);
    clear_inputs();
    $display("txn hint stream, gap2 pulses=%0d", pulses);
    repeat (3) cycle();

    // asynchronous reset right after a done grant
    done_valid = 1'b1; done_app = 4'd3; done_queue = 6'd6; done_addr = 20'h00800; done_len = 16'd32;
    cycle();
    clear_inputs();
    check("pre_reset_free_req", 64'(fm_req[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_free_req", 64'(fm_req[0]), 64'd0);
    check("async_reset_msg_valid", 64'(mv[0]), 64'd0);
    check("async_reset_count", 64'(gcnt[0]), 64'd0);
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("no_replay_%0d", k), 64'(mv[0]), 64'd0);
      cycle();
    end
    $display("txn reset after done grant, no replay");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
